// File: rtl/fifo_pkt_writer.sv
// fifo_pkt_writer: frames an upstream beat stream as header/payload/checksum-trailer words into an async FIFO.
module fifo_pkt_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 64
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  fifo_wen,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_wfull,
  output logic                  pkt_done,
  output logic                  len_err
);
  localparam int CW = $clog2(MAX_LEN + 1);
  typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;
  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] seq, csum;
  logic [CW-1:0]         cnt;
  logic                  acc, last_beat;
  assign acc       = state == DATA && s_valid && !fifo_wfull;
  assign last_beat = s_last || cnt == CW'(MAX_LEN - 1);
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) state <= IDLE;
    else         state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (s_valid ? HDR : IDLE) :
                state == HDR  ? (fifo_wfull ? HDR : DATA) :
                state == DATA ? (acc && last_beat ? TRL : DATA) :
                                (fifo_wfull ? TRL : IDLE);
  always_comb begin
    s_ready    = state == DATA && !fifo_wfull;
    fifo_wen   = !fifo_wfull && (state == HDR || state == TRL || (state == DATA && s_valid));
    pkt_done   = state == TRL && !fifo_wfull;
    fifo_wdata = state == HDR  ? seq :
                 state == DATA ? s_data :
                 state == TRL  ? csum : '0;
  end
  // Truncation is a MAX_LEN-th beat that upstream did not mark last.
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      seq     <= '0;
      csum    <= '0;
      cnt     <= '0;
      len_err <= 1'b0;
    end else if (state == HDR && !fifo_wfull) begin
      seq  <= seq + 1'b1;
      csum <= '0;
      cnt  <= '0;
    end else if (acc) begin
      csum <= csum ^ s_data;
      cnt  <= cnt + 1'b1;
      if (last_beat && !s_last) len_err <= 1'b1;
    end
endmodule

// File: tb/tb_fifo_pkt_writer.sv
// tb_fifo_pkt_writer: randomized and directed checks of fifo_pkt_writer against a stream-framing model.
module tb_fifo_pkt_writer;
  localparam int MAXL = 4;
  logic       wclk, wrst_n, s_valid, s_last, s_ready, fifo_wen, fifo_wfull, pkt_done, len_err;
  logic [7:0] s_data, fifo_wdata;
  int n_checks = 0, n_errors = 0, n_done = 0;
  logic [7:0] drv_d[$], exp_w[$], got[$];
  logic       drv_l[$], exp_t[$];
  logic [7:0] m_seq, m_csum;
  int         m_n;
  logic       m_open, m_len_err;
  logic [7:0] e30[5]  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
  logic [7:0] e32[10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h01, 8'h05, 8'h06, 8'h03};

  fifo_pkt_writer #(.DATA_WIDTH(8), .MAX_LEN(MAXL)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_wfull(fifo_wfull),
    .pkt_done(pkt_done), .len_err(len_err));

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference framing: split the accepted beat stream at last or at MAXL beats.
  task automatic add_beat(input logic [7:0] d, input logic l);
    drv_d.push_back(d);
    drv_l.push_back(l);
    if (!m_open) begin
      exp_w.push_back(m_seq); exp_t.push_back(1'b0);
      m_seq++; m_csum = 0; m_n = 0; m_open = 1'b1;
    end
    exp_w.push_back(d); exp_t.push_back(1'b0);
    m_csum ^= d;
    m_n++;
    if (l || m_n == MAXL) begin
      exp_w.push_back(m_csum); exp_t.push_back(1'b1);
      m_open = 1'b0;
      if (!l) m_len_err = 1'b1;
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic f, output logic a);
    @(negedge wclk);
    s_valid = v; s_data = d; s_last = l; fifo_wfull = f;
    #1;
    a = s_valid && s_ready;
    if (f) begin
      check("stall_wen", fifo_wen, 0);
      check("stall_ready", s_ready, 0);
    end
    if (fifo_wen) begin
      got.push_back(fifo_wdata);
      if (exp_w.size() == 0) check("unexpected_write", fifo_wen, 0);
      else begin
        check("word", fifo_wdata, exp_w.pop_front());
        check("pkt_done", pkt_done, exp_t.pop_front());
      end
    end else check("pkt_done_nowrite", pkt_done, 0);
    if (pkt_done) n_done++;
  endtask

  task automatic step(input int vp, input int fp);
    logic v, f, a, l;
    logic [7:0] d;
    v = drv_d.size() > 0 && int'($urandom_range(99)) < vp;
    d = v ? drv_d[0] : 8'h00;
    l = v ? drv_l[0] : 1'b0;
    f = int'($urandom_range(99)) < fp;
    cycle(v, d, l, f, a);
    if (a) begin
      void'(drv_d.pop_front());
      void'(drv_l.pop_front());
    end
  endtask

  task automatic run(input int vp, input int fp, input int budget);
    int n = 0;
    while ((drv_d.size() > 0 || exp_w.size() > 0) && n < budget) begin
      step(vp, fp);
      n++;
    end
    check("run_pending", drv_d.size() + exp_w.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0; fifo_wfull = 1'b0;
    wrst_n = 1'b0;
    #1;
    check("rst_wen", fifo_wen, 0);
    check("rst_ready", s_ready, 0);
    check("rst_done", pkt_done, 0);
    check("rst_wdata", fifo_wdata, 0);
    check("rst_len_err", len_err, 0);
    repeat (2) @(negedge wclk);
    s_valid = 1'b0;
    wrst_n = 1'b1;
    drv_d.delete(); drv_l.delete(); exp_w.delete(); exp_t.delete(); got.delete();
    m_seq = 0; m_open = 1'b0; m_len_err = 1'b0; n_done = 0;
  endtask

  initial begin
    wrst_n = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; fifo_wfull = 1'b0;
    do_reset();
    // basic packet
    add_beat(8'h11, 1'b0); add_beat(8'h22, 1'b0); add_beat(8'h33, 1'b1);
    run(100, 0, 100);
    for (int i = 0; i < 5; i++) check("single_word", got[i], e30[i]);
    check("single_done_count", n_done, 1);
    add_beat(8'h44, 1'b1);
    run(100, 0, 100);
    check("next_header", got[5], 8'h01);
    // full stall during DATA
    do_reset();
    add_beat(8'h5A, 1'b0); add_beat(8'hC3, 1'b1);
    step(100, 0); step(100, 0);
    for (int i = 0; i < 5; i++) step(100, 100);
    check("stall_words", got.size(), 1);
    check("stall_pending", drv_d.size(), 2);
    run(100, 0, 100);
    check("stall_resume_data", got[1], 8'h5A);
    check("stall_trailer", got[3], 8'h99);
    // truncation at MAX_LEN
    do_reset();
    for (int i = 1; i <= 6; i++) add_beat(8'(i), i == 6);
    run(100, 0, 100);
    check("trunc_count", got.size(), 10);
    for (int i = 0; i < 10; i++) check("trunc_word", got[i], e32[i]);
    check("trunc_len_err", len_err, 1);
    add_beat(8'h09, 1'b1);
    run(100, 0, 100);
    check("len_err_sticky", len_err, 1);
    // reset mid-packet
    do_reset();
    add_beat(8'hAA, 1'b0); add_beat(8'hBB, 1'b0); add_beat(8'hCC, 1'b1);
    repeat (4) step(100, 0);
    check("mid_written", got.size(), 3);
    do_reset();
    repeat (5) step(100, 0);
    check("no_stale_trailer", got.size(), 0);
    add_beat(8'h77, 1'b1);
    run(100, 0, 100);
    check("post_rst_header", got[0], 8'h00);
    check("post_rst_count", got.size(), 3);
    // sequence wrap
    do_reset();
    for (int i = 0; i < 256; i++) add_beat(8'($urandom), 1'b1);
    add_beat(8'h3C, 1'b1);
    run(100, 0, 2000);
    check("wrap_ff", got[255 * 3], 8'hFF);
    check("wrap_00", got[256 * 3], 8'h00);
    // random traffic
    do_reset();
    for (int p = 0; p < 1000; p++) begin
      int len = int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) add_beat(8'($urandom), b == len - 1);
    end
    run(70, 30, 60000);
    check("rand_len_err", len_err, m_len_err);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
